// File: rtl/spi_rgb_pkg.sv
// rtl/spi_rgb_pkg.sv - shared opcodes, FSM encoding and reply length for the SPI RGB controller
package spi_rgb_pkg;

    localparam logic [7:0] OP_WRITE_RGB  = 8'h01;
    localparam logic [7:0] OP_WRITE_CTRL = 8'h02;
    localparam logic [7:0] OP_READ       = 8'h80;

    localparam logic [2:0] REPLY_BYTES   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_WRITE_RGB) || (op == OP_WRITE_CTRL) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/spi_rgb_ctrl_pwm.sv
// rtl/spi_rgb_ctrl_pwm.sv - free-running 8-bit PWM for the three LED drives (module spi_rgb_pwm)
module spi_rgb_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       test_mode,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    logic [7:0] cnt;

    // Strict less-than: 0x00 never lights, 0xFF lights 255 of 256 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'h00;
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            cnt <= cnt + 8'h01;
            if (test_mode) begin
                led_r <= cnt[7];
                led_g <= cnt[7];
                led_b <= cnt[7];
            end else begin
                led_r <= (cnt < duty_r);
                led_g <= (cnt < duty_g);
                led_b <= (cnt < duty_b);
            end
        end
    end

endmodule

// File: rtl/spi_rgb_ctrl.sv
// rtl/spi_rgb_ctrl.sv - oversampled SPI slave decoding RGB duty / test-mode commands; SPI_RGB_PWM_EN selects PWM LED drive
module spi_rgb_ctrl
    import spi_rgb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_mosi,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       test_mode,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    logic clk_s1, clk_s2, clk_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;
    logic rise_p, fall_p, cs_fall_p, cs_rise_p;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [2:0] byte_idx;
    logic [6:0] shift_q;
    logic [7:0] opcode;
    logic [7:0] shadow_r, shadow_g;
    logic [7:0] snap_r, snap_g, snap_b;
    logic       snap_tm;
    logic [7:0] tx_sr;
    logic [7:0] reply;
    logic [7:0] byte_in;

    assign byte_in = {shift_q, mosi_s2};

    // Chip-select chain resets low so a CS held low across reset is not seen as a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1    <= 1'b0;
            clk_s2    <= 1'b0;
            clk_d     <= 1'b0;
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            cs_d      <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            rise_p    <= 1'b0;
            fall_p    <= 1'b0;
            cs_fall_p <= 1'b0;
            cs_rise_p <= 1'b0;
        end else begin
            clk_s1    <= spi_clk;
            clk_s2    <= clk_s1;
            clk_d     <= clk_s2;
            cs_s1     <= spi_cs_n;
            cs_s2     <= cs_s1;
            cs_d      <= cs_s2;
            mosi_s1   <= spi_mosi;
            mosi_s2   <= mosi_s1;
            rise_p    <= clk_s2 & ~clk_d;
            fall_p    <= ~clk_s2 & clk_d;
            cs_fall_p <= ~cs_s2 & cs_d;
            cs_rise_p <= cs_s2 & ~cs_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_idx  <= 3'd0;
            shift_q   <= 7'd0;
            opcode    <= 8'h00;
            shadow_r  <= 8'h00;
            shadow_g  <= 8'h00;
            snap_r    <= 8'h00;
            snap_g    <= 8'h00;
            snap_b    <= 8'h00;
            snap_tm   <= 1'b0;
            duty_r    <= 8'h00;
            duty_g    <= 8'h00;
            duty_b    <= 8'h00;
            test_mode <= 1'b1;
        end else if (cs_rise_p) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            shift_q  <= 7'd0;
            shadow_r <= 8'h00;
            shadow_g <= 8'h00;
        end else if (cs_fall_p) begin
            state    <= ST_CMD;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            shift_q  <= 7'd0;
            shadow_r <= 8'h00;
            shadow_g <= 8'h00;
        end else if (rise_p && state != ST_IDLE) begin
            shift_q <= byte_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                case (state)
                    ST_CMD: begin
                        if (is_known_op(byte_in)) begin
                            opcode   <= byte_in;
                            state    <= ST_DATA;
                            byte_idx <= 3'd1;
                            snap_r   <= duty_r;
                            snap_g   <= duty_g;
                            snap_b   <= duty_b;
                            snap_tm  <= test_mode;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_DATA: begin
                        byte_idx <= byte_idx + 3'd1;
                        if (opcode == OP_WRITE_RGB) begin
                            if (byte_idx == 3'd1) begin
                                shadow_r <= byte_in;
                            end else if (byte_idx == 3'd2) begin
                                shadow_g <= byte_in;
                            end else begin
                                duty_r <= shadow_r;
                                duty_g <= shadow_g;
                                duty_b <= byte_in;
                                state  <= ST_IGNORE;
                            end
                        end else if (opcode == OP_WRITE_CTRL) begin
                            test_mode <= byte_in[0];
                            state     <= ST_IGNORE;
                        end else if (byte_idx == REPLY_BYTES) begin
                            state <= ST_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        reply = 8'h00;
        if (state == ST_DATA && opcode == OP_READ) begin
            case (byte_idx)
                3'd1:    reply = snap_r;
                3'd2:    reply = snap_g;
                3'd3:    reply = snap_b;
                3'd4:    reply = {7'b0, snap_tm};
                default: reply = 8'h00;
            endcase
        end
    end

    // A fall with bit_cnt back at 0 follows the last rise of a byte: load the next reply MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_miso <= 1'b0;
            tx_sr    <= 8'h00;
        end else if (cs_s2) begin
            spi_miso <= 1'b0;
            tx_sr    <= 8'h00;
        end else if (fall_p) begin
            if (bit_cnt == 3'd0) begin
                spi_miso <= reply[7];
                tx_sr    <= {reply[6:0], 1'b0};
            end else begin
                spi_miso <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_RGB_PWM_EN
    spi_rgb_pwm u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_mode (test_mode),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b)
    );
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= test_mode | duty_r[7];
            led_g <= test_mode | duty_g[7];
            led_b <= test_mode | duty_b[7];
        end
    end
`endif

endmodule

// File: tb/tb_spi_rgb_ctrl.sv
// tb/tb_spi_rgb_ctrl.sv - scoreboard bench for spi_rgb_ctrl: register commits, MISO readback, abort, reset
module tb_spi_rgb_ctrl;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso;
    logic       test_mode;
    logic [7:0] duty_r, duty_g, duty_b;
    logic       led_r, led_g, led_b;

    spi_rgb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_mosi  (spi_mosi),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .test_mode (test_mode),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   last_rise_cyc = 0;
    logic mon_en = 1'b0;

    logic [24:0] exp_regs_q[$];
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Register monitor: every change of {duty_r,duty_g,duty_b,test_mode} must match the next expected commit.
    initial begin
        logic [24:0] prev, cur, e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {duty_r, duty_g, duty_b, test_mode};
            if (!mon_en) begin
                prev = cur;
            end else if (cur !== prev) begin
                if (exp_regs_q.size() == 0) begin
                    check("unexpected_reg_change", {7'b0, cur}, {7'b0, prev});
                end else begin
                    e = exp_regs_q.pop_front();
                    check("commit_value", {7'b0, cur}, {7'b0, e});
                    check("commit_latency", cyc - last_rise_cyc, 4);
                end
                prev = cur;
            end
        end
    end

    // MISO monitor: each byte the master captured is compared with the next expected reply byte.
    initial begin
        logic [7:0] a;
        forever begin
            @(negedge clk);
            while (rx_q.size() > 0) begin
                a = rx_q.pop_front();
                if (exp_miso_q.size() == 0)
                    check("miso_unexpected", {24'b0, a}, 32'hFFFF_FFFF);
                else
                    check("miso_byte", {24'b0, a}, {24'b0, exp_miso_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input bit chk, input logic [7:0] exp);
        logic [7:0] rx;
        rx = 8'h00;
        if (chk) exp_miso_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            spi_clk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(HALF);
            rx[i] = spi_miso;
            spi_clk = 1'b0;
        end
        if (chk) rx_q.push_back(rx);
    endtask

    initial begin
        logic [7:0] rd_exp [6];
        wait_clk(3);
        check("reset_duty_r", {24'b0, duty_r}, 32'h00);
        check("reset_duty_g", {24'b0, duty_g}, 32'h00);
        check("reset_duty_b", {24'b0, duty_b}, 32'h00);
        check("reset_test_mode", {31'b0, test_mode}, 32'h1);
        check("reset_miso", {31'b0, spi_miso}, 32'h0);
        check("reset_leds", {29'b0, led_r, led_g, led_b}, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);
`ifndef SPI_RGB_PWM_EN
        check("testmode_leds_on", {29'b0, led_r, led_g, led_b}, 32'h7);
`endif
        mon_en = 1'b1;

        // Write RGB
        exp_regs_q.push_back({8'h12, 8'h34, 8'h56, 1'b1});
        frame_start();
        spi_byte(8'h01, 0, 8'h00);
        spi_byte(8'h12, 1, 8'h00);
        spi_byte(8'h34, 1, 8'h00);
        spi_byte(8'h56, 1, 8'h00);
        spi_byte(8'h77, 1, 8'h00);
        frame_end();

        // Aborted write: no commit expected
        frame_start();
        spi_byte(8'h01, 0, 8'h00);
        spi_byte(8'hAA, 1, 8'h00);
        spi_byte(8'hBB, 1, 8'h00);
        frame_end();

        exp_regs_q.push_back({8'h12, 8'h34, 8'h56, 1'b0});
        frame_start();
        spi_byte(8'h02, 0, 8'h00);
        spi_byte(8'h00, 1, 8'h00);
        frame_end();

        // Readback
        rd_exp = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
        frame_start();
        spi_byte(8'h80, 0, 8'h00);
        for (int i = 1; i < 6; i++) spi_byte(8'h00, 1, rd_exp[i]);
        frame_end();
        check("miso_idle_low", {31'b0, spi_miso}, 32'h0);

        // Unknown opcode
        frame_start();
        spi_byte(8'h55, 0, 8'h00);
        spi_byte(8'hFF, 1, 8'h00);
        spi_byte(8'hFF, 1, 8'h00);
        frame_end();

        exp_regs_q.push_back({8'h40, 8'h00, 8'hC0, 1'b0});
        frame_start();
        spi_byte(8'h01, 0, 8'h00);
        spi_byte(8'h40, 1, 8'h00);
        spi_byte(8'h00, 1, 8'h00);
        spi_byte(8'hC0, 1, 8'h00);
        frame_end();

`ifdef SPI_RGB_PWM_EN
        begin
            int hr, hg, hb;
            hr = 0; hg = 0; hb = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                hr += int'(led_r);
                hg += int'(led_g);
                hb += int'(led_b);
            end
            check("pwm_r_high_count", hr, 64);
            check("pwm_g_high_count", hg, 0);
            check("pwm_b_high_count", hb, 192);
        end
`else
        check("onoff_leds", {29'b0, led_r, led_g, led_b}, 32'h1);
`endif

        // Asynchronous reset in the middle of a frame
        frame_start();
        spi_byte(8'h01, 0, 8'h00);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_duty", {8'b0, duty_r, duty_g, duty_b}, 32'h0);
        check("midreset_test_mode", {31'b0, test_mode}, 32'h1);
        check("midreset_miso", {31'b0, spi_miso}, 32'h0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        mon_en = 1'b1;
        spi_byte(8'h01, 0, 8'h00);
        spi_byte(8'h9A, 0, 8'h00);
        spi_byte(8'h9B, 0, 8'h00);
        spi_byte(8'h9C, 0, 8'h00);
        frame_end();

        exp_regs_q.push_back({8'h11, 8'h22, 8'h33, 1'b1});
        frame_start();
        spi_byte(8'h01, 0, 8'h00);
        spi_byte(8'h11, 1, 8'h00);
        spi_byte(8'h22, 1, 8'h00);
        spi_byte(8'h33, 1, 8'h00);
        frame_end();

        for (int i = 0; i < 1000 && (rx_q.size() > 0 || exp_regs_q.size() > 0); i++)
            @(negedge clk);
        wait_clk(2);
        check("commits_drained", exp_regs_q.size(), 0);
        check("miso_drained", exp_miso_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rgb_ctrl.md
# spi_rgb_ctrl

SPI slave command decoder that sits between the ESP32 SPI link (`spi_mosi`/`spi_miso`/`spi_clk`/`spi_cs_n`) and the RGB LED driver. It oversamples the SPI pins in the system clock domain and decodes byte-framed commands into an 8-bit duty value per colour plus a test-mode flag. It also returns the register contents on MISO so the ESP32 can read back what the FPGA holds. Its outputs feed the `test_mode` and `in_r`/`in_g`/`in_b` inputs of the RGB LED wrapper.

## Interface
- `clk`  in  1  system clock from the PLL; all logic is in this domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_mosi`  in  1  SPI data in, asynchronous to `clk`.
- `spi_clk`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `spi_cs_n`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `spi_miso`  out  1  SPI data out, MSB first. Driven 0 while `spi_cs_n` is high.
- `test_mode`  out  1  test-mode flag for the LED wrapper.
- `duty_r`  out  8  registered red duty value.
- `duty_g`  out  8  registered green duty value.
- `duty_b`  out  8  registered blue duty value.
- `led_r`  out  1  per-colour LED drive (see Configuration).
- `led_g`  out  1  per-colour LED drive (see Configuration).
- `led_b`  out  1  per-colour LED drive (see Configuration).

## Operation
- Input conditioning:
  - `spi_clk`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchronizer.
  - SPI clock rise and fall are detected on the synchronized `spi_clk`.
  - `spi_mosi` is sampled on the detected rise, and the bit is shifted in MSB first.
- Framing:
  - A frame starts when synchronized `spi_cs_n` falls.
  - The bit counter (3 bits) wraps every 8 rises.
  - Byte 0 of a frame is the command byte.
- Commands:
  - `0x01` WRITE_RGB: bytes 1..3 are R, G, B. They go into a shadow register, and all three duties are committed together after byte 3 completes. Bytes 4 and later are ignored.
  - `0x02` WRITE_CTRL: bit 0 of byte 1 is committed to `test_mode`. Bytes 2 and later are ignored.
  - `0x80` READ: MISO returns R, G, B during bytes 1..3, then `{7'b0, test_mode}` during byte 4, then 0x00 for the rest of the frame. The values are snapshotted when the command byte completes.
  - Any other value: go to IGNORE. MISO stays 0 and no state changes.
- FSM states: IDLE, CMD, DATA, IGNORE.
  - IDLE → CMD on `spi_cs_n` fall.
  - CMD → DATA when the command byte completes with a known opcode; CMD → IGNORE for an unknown opcode.
  - DATA → IGNORE once the command's byte count is exhausted.
  - Any state → IDLE on synchronized `spi_cs_n` rise.
- Abort: if `spi_cs_n` rises mid-frame, partial shadow data is discarded, committed registers are unchanged, and the bit counter is cleared.
- MISO: the next bit is presented on the detected SPI clock fall. The MSB of a reply byte is loaded on the fall that follows the last rise of the previous byte.
- Reset values:
  - `duty_r`/`duty_g`/`duty_b` = 0x00, `test_mode` = 1, `spi_miso` = 0, `led_*` = 0.
  - FSM = IDLE; shift register, bit counter and shadow registers = 0.
- Reset mid-frame: all state returns to reset values immediately (asynchronously). The frame in progress is lost, and the next frame is decoded only after a fresh `spi_cs_n` fall.

## Timing
- Supported `spi_clk` is at most `clk`/8, with each SPI clock high and low phase lasting at least 4 `clk` cycles.
- The edge-detect pulse occurs 3 `clk` cycles after the pin edge (2 sync stages + 1 edge register).
- Commit: `duty_*`/`test_mode` update on the `clk` edge after the edge-detect pulse of the final bit of the committing byte, i.e. 4 `clk` cycles after that SPI rise.
- `spi_miso` changes 4 `clk` cycles after an SPI clock fall.
- Back-to-back frames need at least 4 `clk` cycles of `spi_cs_n` high.

## Configuration
- `SPI_RGB_PWM_EN` defined:
  - The `spi_rgb_pwm` sub-module drives `led_*` from a free-running 8-bit counter.
  - `led_x` = (counter < `duty_x`); duty 0x00 is always off and 0xFF is on for 255 of every 256 cycles.
  - With `test_mode`=1, all `led_*` = counter[7].
- `SPI_RGB_PWM_EN` undefined:
  - No counter is built; `led_x` = `duty_x[7]` (on/off).
  - With `test_mode`=1, all `led_*` = 1.

## Structure
- Shared package `spi_rgb_pkg`:
  - opcode constants `OP_WRITE_RGB`=8'h01, `OP_WRITE_CTRL`=8'h02, `OP_READ`=8'h80;
  - FSM state encoding (2 bits);
  - reply byte count (4).
- One sub-module, `spi_rgb_pwm` (counter + comparators, instantiated only under `SPI_RGB_PWM_EN`).
- The synchronizers are inline.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → `duty_*`=0, `test_mode`=1, `spi_miso`=0 within the same cycle.
- Write RGB: frame 01 12 34 56 at `clk`/8 → `duty_r`=0x12, `duty_g`=0x34, `duty_b`=0x56 all changing in the same `clk` cycle, 4 cycles after the last rise.
- Abort: frame 01 AA BB, then `spi_cs_n` rises → duties keep their previous values; the next frame 02 00 sets `test_mode`=0.
- Readback: after the writes above, frame 80 00 00 00 00 00 → MISO bytes xx 12 34 56 00 00 (the last byte is 00 since `test_mode`=0).
- Unknown opcode: frame 55 FF FF → no register change, MISO all 0, and the next frame decodes normally.
- PWM (with `SPI_RGB_PWM_EN`): `duty_r`=0x40, `test_mode`=0 → `led_r` high for 64 of every 256 cycles; `duty_g`=0x00 → `led_g` always low.
